vga_timing_out: RTL and testbench

Generates 640x480@60 VGA raster timing from the 25.175 MHz pixel clock and drives the TinyVGA PMOD output pins. It sits on both sides of the graphics colour logic. It supplies `hpos`/`vpos`/`display_on`/frame information upstream to the colour logic. It accepts the resulting 6-bit colour the same cycle, then registers colour and sync together into the 8-bit PMOD word that drives `uo_out`.

---
 rtl/vga_timing_out_if.sv | 23 ++
 rtl/vga_timing_out.sv | 85 ++++++++
 tb/tb_vga_timing_out.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_out_if.sv
// Raster bus between the VGA timing core and the colour logic:
// position/frame info goes out, colour comes back, PMOD word goes out.
interface vga_timing_out_if #(
  parameter int FRAME_W = 8
);
  logic [5:0]         rgb_in;
  logic [9:0]         hpos;
  logic [9:0]         vpos;
  logic               display_on;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_cnt;
  logic [7:0]         vga_pmod;

  modport master (
    input  rgb_in,
    output hpos, vpos, display_on, frame_start, frame_cnt, vga_pmod
  );

  modport slave (
    output rgb_in,
    input  hpos, vpos, display_on, frame_start, frame_cnt, vga_pmod
  );
endinterface

// File: rtl/vga_timing_out.sv
// 640x480@60 raster timing generator driving the TinyVGA PMOD word.
// Define VGA_FRAME_CNT_EN to build the completed-frame counter; otherwise frame_cnt is 0.
module vga_timing_out #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int FRAME_W  = 8
) (
  input  logic           clk,
  input  logic           rst,
  vga_timing_out_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic [7:0] pmod_q, pmod_d;
  logic       h_last, v_last, disp, fstart, hsync_n, vsync_n;
  logic [5:0] col;

  always_comb begin
    h_last  = (hpos_q == H_LAST);
    v_last  = (vpos_q == V_LAST);
    disp    = (hpos_q < H_VIS) && (vpos_q < V_VIS);
    fstart  = h_last && v_last;
    hsync_n = !((hpos_q >= HS_BEG) && (hpos_q <= HS_END));
    vsync_n = !((vpos_q >= VS_BEG) && (vpos_q <= VS_END));

    hpos_d = h_last ? 10'd0 : hpos_q + 10'd1;
    vpos_d = vpos_q;
    if (h_last) vpos_d = v_last ? 10'd0 : vpos_q + 10'd1;

    // Colour is blanked here so the PMOD word never carries colour outside the visible area.
    col    = disp ? bus.rgb_in : 6'd0;
    pmod_d = {hsync_n, col[0], col[2], col[4], vsync_n, col[1], col[3], col[5]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hpos_q <= '0;
      vpos_q <= '0;
      pmod_q <= 8'h88;
    end else begin
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
      pmod_q <= pmod_d;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_W-1:0] frame_q, frame_d;

  assign frame_d = fstart ? frame_q + FRAME_W'(1) : frame_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_q <= '0;
    else     frame_q <= frame_d;
  end

  assign bus.frame_cnt = frame_q;
`else
  assign bus.frame_cnt = '0;
`endif

  assign bus.hpos        = hpos_q;
  assign bus.vpos        = vpos_q;
  assign bus.display_on  = disp;
  assign bus.frame_start = fstart;
  assign bus.vga_pmod    = pmod_q;
endmodule

// File: tb/tb_vga_timing_out.sv
// Bench: a full-size instance for line-level timing and a shrunken-raster instance
// for frame-level behaviour, both checked every cycle against an arithmetic model.
module tb_vga_timing_out;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic mode_b;
  logic [5:0] rnd_a, rnd_b, snap_a, snap_b;
  int n_chk = 0, n_pass = 0;

  // Small raster: 30 x 17 = 510 cycles per frame, 4-bit frame counter.
  localparam int SHA = 16, SHF = 4, SHS = 6, SHB = 4;
  localparam int SVA = 10, SVF = 2, SVS = 2, SVB = 3;
  localparam int SFW = 4;

  always #5 clk = ~clk;

  vga_timing_out_if #(.FRAME_W(8))   ifa ();
  vga_timing_out_if #(.FRAME_W(SFW)) ifb ();

  assign ifa.rgb_in = (ifa.hpos == 10'd10 && ifa.vpos == 10'd10) ? 6'b100110 : rnd_a;
  assign ifb.rgb_in = mode_b ? 6'b111111 : rnd_b;

  vga_timing_out dut_a (.clk(clk), .rst(rst_a), .bus(ifa));

  vga_timing_out #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .FRAME_W(SFW)
  ) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
  endtask

  // Expected PMOD word for raster position t (cycles since reset release) with colour rgb.
  function automatic logic [7:0] pm(input int t, input logic [5:0] rgb,
                                     input int ha, hf, hs, hb, va, vf, vs, vb);
    int ht, vt, h, v;
    logic hsn, vsn;
    logic [5:0] c;
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    h   = t % ht;
    v   = (t / ht) % vt;
    hsn = !(h >= ha + hf && h < ha + hf + hs);
    vsn = !(v >= va + vf && v < va + vf + vs);
    c   = (h < ha && v < va) ? rgb : 6'd0;
    return {hsn, c[0], c[2], c[4], vsn, c[1], c[3], c[5]};
  endfunction

  task automatic chk_all(input string p, input int t, input logic [7:0] ep,
                         input logic [9:0] h, input logic [9:0] v, input logic d,
                         input logic fs, input logic [63:0] fc, input logic [7:0] pmod,
                         input int ha, hf, hs, hb, va, vf, vs, vb, fw);
    int ht, vt, eh, ev;
    logic [63:0] efc;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    eh = t % ht;
    ev = (t / ht) % vt;
`ifdef VGA_FRAME_CNT_EN
    efc = 64'((t / (ht * vt)) % (1 << fw));
`else
    efc = 64'd0;
`endif
    chk({p, "_hpos"}, 64'(h), 64'(eh));
    chk({p, "_vpos"}, 64'(v), 64'(ev));
    chk({p, "_disp"}, 64'(d), 64'(eh < ha && ev < va));
    chk({p, "_fstart"}, 64'(fs), 64'(eh == ht - 1 && ev == vt - 1));
    chk({p, "_fcnt"}, fc, efc);
    chk({p, "_pmod"}, 64'(pmod), 64'(ep));
  endtask

  // Reference state: edges since reset release and the expected registered word.
  int ta, tb;
  logic [7:0] epa, epb;

  always @(posedge clk or posedge rst_a)
    if (rst_a) begin ta <= 0; epa <= 8'h88; end
    else begin
      epa <= pm(ta, snap_a, 640, 16, 96, 48, 480, 10, 2, 33);
      ta  <= ta + 1;
    end

  always @(posedge clk or posedge rst_b)
    if (rst_b) begin tb <= 0; epb <= 8'h88; end
    else begin
      epb <= pm(tb, snap_b, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB);
      tb  <= tb + 1;
    end

  logic px_flag = 1'b0;
  int   px_hit = 0;

  always @(negedge clk) begin
    chk_all("a", ta, epa, ifa.hpos, ifa.vpos, ifa.display_on, ifa.frame_start,
            64'(ifa.frame_cnt), ifa.vga_pmod, 640, 16, 96, 48, 480, 10, 2, 33, 8);
    chk_all("b", tb, epb, ifb.hpos, ifb.vpos, ifb.display_on, ifb.frame_start,
            64'(ifb.frame_cnt), ifb.vga_pmod, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, SFW);
    if (px_flag) begin
      chk("pix10_10_pmod", 64'(ifa.vga_pmod), 64'(8'b1010_1101));
      px_hit++;
    end
    px_flag = !rst_a && ifa.hpos == 10'd10 && ifa.vpos == 10'd10;
    rnd_a = 6'($urandom_range(0, 63));
    rnd_b = 6'($urandom_range(0, 63));
    #1;
    snap_a = ifa.rgb_in;
    snap_b = ifb.rgb_in;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_low, lit, vs_low, fs_n, found, fc_prev, saw_max, saw_wrap, fc_nz;
    rst_a = 1'b1; rst_b = 1'b1; mode_b = 1'b0;
    rnd_a = '0; rnd_b = '0; snap_a = '0; snap_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_pmod_a", 64'(ifa.vga_pmod), 64'h88);
    chk("rst_disp_a", 64'(ifa.display_on), 64'd1);
    rst_a = 1'b0; rst_b = 1'b0;

    // One full line of the full-size raster.
    hs_low = 0;
    for (int k = 1; k <= 800; k++) begin
      @(negedge clk);
      if (k == 1) chk("first_hpos", 64'(ifa.hpos), 64'd1);
      if (!ifa.vga_pmod[7]) hs_low++;
      if (ifa.hpos == 10'd656) chk("hs_before", 64'(ifa.vga_pmod[7]), 64'd1);
      if (ifa.hpos == 10'd657) chk("hs_first", 64'(ifa.vga_pmod[7]), 64'd0);
    end
    chk("hs_low_cnt", 64'(hs_low), 64'd96);
    chk("line_wrap_h", 64'(ifa.hpos), 64'd0);
    chk("line_wrap_v", 64'(ifa.vpos), 64'd1);

    // Full white frame on the small raster.
    found = 0;
    for (int k = 0; k < 2000 && found == 0; k++) begin
      @(negedge clk);
      if (ifb.hpos == 10'd0 && ifb.vpos == 10'd0) found = 1;
    end
    chk("find_frame_b", 64'(found), 64'd1);
    mode_b = 1'b1;
    lit = 0; vs_low = 0; fs_n = 0;
    for (int k = 1; k <= 510; k++) begin
      @(negedge clk);
      if (ifb.vga_pmod[6:4] == 3'b111 && ifb.vga_pmod[2:0] == 3'b111) lit++;
      if (!ifb.vga_pmod[3]) vs_low++;
      if (ifb.frame_start) fs_n++;
    end
    mode_b = 1'b0;
    chk("lit_cnt", 64'(lit), 64'd160);
    chk("vs_low_cnt", 64'(vs_low), 64'd60);
    chk("fstart_per_frame", 64'(fs_n), 64'd1);

    // Frame counter across its wrap point.
    fc_prev = int'(ifb.frame_cnt); saw_max = 0; saw_wrap = 0; fc_nz = 0;
    for (int k = 0; k < 9000; k++) begin
      @(negedge clk);
      if (ifb.frame_cnt == 4'd15) saw_max = 1;
      if (fc_prev == 15 && ifb.frame_cnt == 4'd0) saw_wrap = 1;
      if (ifb.frame_cnt != 4'd0) fc_nz = 1;
      fc_prev = int'(ifb.frame_cnt);
    end
`ifdef VGA_FRAME_CNT_EN
    chk("fcnt_max_seen", 64'(saw_max), 64'd1);
    chk("fcnt_wrap_seen", 64'(saw_wrap), 64'd1);
`else
    chk("fcnt_stays_zero", 64'(fc_nz), 64'd0);
`endif

    // Asynchronous reset between edges, mid-line and mid-frame.
    found = 0;
    for (int k = 0; k < 1000 && found == 0; k++) begin
      @(negedge clk);
      if (ifb.hpos == 10'd20 && ifb.vpos == 10'd7) found = 1;
    end
    chk("find_mid_b", 64'(found), 64'd1);
    #2 rst_b = 1'b1;
    #1;
    chk("arst_hpos", 64'(ifb.hpos), 64'd0);
    chk("arst_vpos", 64'(ifb.vpos), 64'd0);
    chk("arst_pmod", 64'(ifb.vga_pmod), 64'h88);
    chk("arst_disp", 64'(ifb.display_on), 64'd1);
    chk("arst_fstart", 64'(ifb.frame_start), 64'd0);
    chk("arst_fcnt", 64'(ifb.frame_cnt), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    chk("restart_hpos", 64'(ifb.hpos), 64'd1);
    chk("restart_vpos", 64'(ifb.vpos), 64'd0);
    repeat (20) @(negedge clk);

    chk("pix10_10_seen", 64'(px_hit), 64'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
